fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Serial FIR engine for the ANC filter path. Time-shares one 11-bit sign-magnitude multiplier across TAPS coefficient/sample pairs.
- Each accepted input sample is shifted into a delay line. The block then runs TAPS multiply-accumulate cycles and emits one sign-magnitude output sample with a valid pulse.
- Coefficient RAM is register-based and written through a simple port while the engine is idle.

Parameters:
- TAPS, 16, number of filter taps (2..64).
- FRAC, 10, right-shift applied to the accumulator magnitude to return from Q0.20 to Q0.10.
- ACC_W, 20+$clog2(TAPS)+1, two's-complement accumulator width (25 at default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  11  input sample, sign-magnitude: bit10 = sign, bits9:0 = magnitude (Q0.10).
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  engine can accept a sample (high only in IDLE).
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  6  tap index to write.
- coef_data  in  11  coefficient, sign-magnitude Q0.10.
- y_out  out  11  filter output, sign-magnitude Q0.10; holds last result.
- y_valid  out  1  one-cycle pulse when y_out updates.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, sample_ready=1 (comb from state), y_out=0, y_valid=0, acc=0, tap index=0, all delay-line and coefficient registers=0.
- FSM IDLE:
  - sample_valid & sample_ready → x[0]<=sample_in, x[k]<=x[k-1], acc<=0, idx<=0, go MAC.
  - Otherwise stay in IDLE.
- FSM MAC:
  - Each cycle: p = Multiplier(x[idx], h[idx]), 21-bit sign-magnitude.
  - Convert p to ACC_W two's complement: negate magnitude if p[20]; a magnitude of 0 with sign 1 yields 0.
  - acc <= acc + conv(p); idx <= idx+1.
  - If idx==TAPS-1, go DONE.
- FSM DONE:
  - mag = |acc| >> FRAC, truncation toward zero.
  - If mag > 1023, saturate to 1023.
  - sign = acc<0 && mag!=0, so negative zero is never output.
  - y_out <= {sign, mag[9:0]}, y_valid <= 1 for this cycle only, go IDLE.
- Latency: sample accepted at edge E0; y_valid high in the cycle after edge E0+TAPS+1. At default TAPS this is 17 clocks sample-to-result; max throughput is one sample per TAPS+2 cycles.
- Coefficient writes:
  - Accepted only in IDLE and only when coef_addr < TAPS: h[coef_addr] <= coef_data.
  - Writes while busy, or to an out-of-range address, are silently dropped.
- Simultaneous sample accept and coef write in IDLE: both take effect at the same edge, so the MAC uses the new coefficient.
- sample_valid while not ready: ignored (not latched); the sender must hold it.
- rst mid-MAC or in DONE: the result is discarded and no y_valid is produced. The engine returns to IDLE the next cycle with delay line and coefficients cleared.
- Arithmetic: the multiplier is purely combinational, so no pipeline register sits in the MAC path. The accumulator cannot overflow at ACC_W (|sum| < TAPS·2^20).

Decomposition:
- Shared package anc_pkg:
  - Constants SM_W=11, MAG_W=10, PROD_W=21.
  - State enum {IDLE, MAC, DONE}.
  - Functions sm_to_tc(value, width) and tc_to_sm_sat(value, frac).
- One sub-module: instantiate the team's existing Multiplier block (11×11 sign-magnitude → 21-bit) as u_mult. Do not re-implement it.

Test Plan:
- h[0]=11'h200 (+0.5), other taps 0; sample +1000 (11'h3E8) → y_out=11'h1F4 (+500), y_valid exactly 17 cycles after acceptance, sample_ready low for cycles 1..17.
- h[0]=11'h600 (−0.5), sample +1000 → y_out=11'h5F4 (−500).
- h[0]=h[1]=11'h200; samples +600 then −600 (11'h658) → outputs 11'h12C (+300) then 11'h000, with no negative zero.
- All 16 h=11'h3FF; sixteen samples of 11'h3FF → 16th output saturates to 11'h3FF. Repeat with negative samples → 11'h7FF.
- Coef write to tap 0 during MAC, and write with coef_addr=20 in IDLE → both ignored; next output unchanged from the expected value.
- rst asserted at the 5th MAC cycle → no y_valid; sample_ready=1 the next cycle; new sample +1000 with cleared coefficients → y_out=11'h000.

Source files
------------

// File: rtl/anc_pkg.sv
// anc_pkg: shared sign-magnitude constants, FSM states and format conversions for the ANC filter path.
package anc_pkg;
    localparam int SM_W   = 11;
    localparam int MAG_W  = 10;
    localparam int PROD_W = 21;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    function automatic logic signed [63:0] sm_to_tc(input logic [63:0] value, input int width);
        logic [63:0] mag;
        mag = value & ((64'd1 << (width - 1)) - 64'd1);
        return value[width-1] ? -$signed(mag) : $signed(mag);
    endfunction

    // A zero magnitude always comes back positive, so negative zero never escapes.
    function automatic logic [SM_W-1:0] tc_to_sm_sat(input logic signed [63:0] value, input int frac);
        logic [63:0] mag;
        mag = value[63] ? 64'(-value) : 64'(value);
        mag = mag >> frac;
        if (mag > 64'd1023) mag = 64'd1023;
        return {value[63] && (mag != 64'd0), mag[MAG_W-1:0]};
    endfunction
endpackage

// File: rtl/Multiplier.sv
// Multiplier: combinational 11x11 sign-magnitude multiply producing a 21-bit sign-magnitude product.
module Multiplier (
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic [20:0] p
);
    assign p = {a[10] ^ b[10], 20'(a[9:0]) * 20'(b[9:0])};
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: serial FIR that time-shares one sign-magnitude multiplier across all taps.
module fir_mac_sequencer
    import anc_pkg::*;
#(
    parameter int TAPS  = 16,
    parameter int FRAC  = 10,
    parameter int ACC_W = 20 + $clog2(TAPS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SM_W-1:0]   sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              coef_we,
    input  logic [5:0]        coef_addr,
    input  logic [SM_W-1:0]   coef_data,
    output logic [SM_W-1:0]   y_out,
    output logic              y_valid
);
    localparam int IDX_W = $clog2(TAPS);

    state_t                   state_q;
    logic [SM_W-1:0]          x_q [TAPS];
    logic [SM_W-1:0]          h_q [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q;
    logic [SM_W-1:0]          y_out_q, y_d;
    logic                     y_valid_q;
    logic [PROD_W-1:0]        prod;
    logic                     coef_ok;

    Multiplier u_mult (
        .a (x_q[idx_q]),
        .b (h_q[idx_q]),
        .p (prod)
    );

    always_comb begin
        acc_d   = acc_q + ACC_W'(sm_to_tc(64'(prod), PROD_W));
        y_d     = tc_to_sm_sat(64'(acc_q), FRAC);
        coef_ok = (state_q == IDLE) && coef_we && ({1'b0, coef_addr} < 7'(TAPS));
    end

    assign sample_ready = (state_q == IDLE);
    assign y_out        = y_out_q;
    assign y_valid      = y_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            y_valid_q <= 1'b0;
            // A write landing on the accepting edge is seen by the MAC that follows.
            if (coef_ok) h_q[coef_addr[IDX_W-1:0]] <= coef_data;
            case (state_q)
                IDLE: if (sample_valid) begin
                    x_q[0] <= sample_in;
                    for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(TAPS - 1)) state_q <= DONE;
                end
                DONE: begin
                    y_out_q   <= y_d;
                    y_valid_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vector table plus hand-written sequences for the FIR MAC sequencer.
module tb_fir_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        coef_we = 1'b0;
    logic [5:0]  coef_addr = '0;
    logic [10:0] coef_data = '0;
    logic [10:0] y_out;
    logic        y_valid;

    int checks = 0;
    int errors = 0;

    fir_mac_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .y_out        (y_out),
        .y_valid      (y_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          do_rst;
        logic [10:0] h0;
        logic [10:0] h1;
        logic [10:0] s;
        logic [10:0] exp_y;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wcoef(input logic [5:0] a, input logic [10:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [10:0] s);
        @(negedge clk);
        sample_valid = 1'b1; sample_in = s;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Called right after send(): n counts edges since acceptance.
    task automatic wait_y(output logic [10:0] y, output int lat, output bit busy_ok);
        lat = -1; y = 'x; busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (y_valid) begin
                lat = n; y = y_out;
                break;
            end
            if (sample_ready) busy_ok = 1'b0;
        end
    endtask

    logic [10:0] y;
    int          lat;
    bit          busy_ok;
    bit          seen;

    initial begin
        vecs[0] = '{"pos_half",   1'b1, 11'h200, 11'h000, 11'h3E8, 11'h1F4};
        vecs[1] = '{"neg_half",   1'b1, 11'h600, 11'h000, 11'h3E8, 11'h5F4};
        vecs[2] = '{"two_tap_a",  1'b1, 11'h200, 11'h200, 11'h258, 11'h12C};
        vecs[3] = '{"two_tap_b",  1'b0, 11'h200, 11'h200, 11'h658, 11'h000};

        do_reset();
        check("rst_y_out", 32'(y_out), 32'h0);
        check("rst_y_valid", 32'(y_valid), 32'h0);
        check("rst_ready", 32'(sample_ready), 32'h1);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].do_rst) do_reset();
            wcoef(6'd0, vecs[i].h0);
            wcoef(6'd1, vecs[i].h1);
            send(vecs[i].s);
            wait_y(y, lat, busy_ok);
            check({vecs[i].name, "_y"}, 32'(y), 32'(vecs[i].exp_y));
            check({vecs[i].name, "_lat"}, 32'(lat), 32'd17);
            check({vecs[i].name, "_busy"}, 32'(busy_ok), 32'd1);
        end

        // Saturation, positive then negative.
        for (int sgn = 0; sgn < 2; sgn++) begin
            do_reset();
            for (int t = 0; t < 16; t++) wcoef(6'(t), 11'h3FF);
            for (int k = 1; k <= 16; k++) begin
                send(sgn != 0 ? 11'h7FF : 11'h3FF);
                wait_y(y, lat, busy_ok);
                if (k == 1) check(sgn != 0 ? "sat_neg_first" : "sat_pos_first", 32'(y), sgn != 0 ? 32'h7FE : 32'h3FE);
                if (k == 16) check(sgn != 0 ? "sat_neg_last" : "sat_pos_last", 32'(y), sgn != 0 ? 32'h7FF : 32'h3FF);
            end
        end

        // Coefficient write while busy must be dropped.
        do_reset();
        wcoef(6'd0, 11'h200);
        send(11'h3E8);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 6'd0; coef_data = 11'h3FF;
        @(negedge clk);
        coef_we = 1'b0;
        wait_y(y, lat, busy_ok);
        check("busy_write_y", 32'(y), 32'h1F4);
        for (int k = 0; k < 5; k++) begin
            send(11'h3E8);
            wait_y(y, lat, busy_ok);
        end
        // Address 20 would alias onto tap 4, which now holds a nonzero sample.
        wcoef(6'd20, 11'h200);
        send(11'h3E8);
        wait_y(y, lat, busy_ok);
        check("oob_write_y", 32'(y), 32'h1F4);

        // Simultaneous accept and coefficient write: the new coefficient is used.
        do_reset();
        @(negedge clk);
        sample_valid = 1'b1; sample_in = 11'h3E8;
        coef_we = 1'b1; coef_addr = 6'd0; coef_data = 11'h600;
        @(negedge clk);
        sample_valid = 1'b0; coef_we = 1'b0;
        wait_y(y, lat, busy_ok);
        check("same_edge_y", 32'(y), 32'h5F4);

        // Reset during the fifth MAC cycle discards the result.
        do_reset();
        wcoef(6'd0, 11'h200);
        send(11'h3E8);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(sample_ready), 32'h1);
        seen = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (y_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 32'(seen), 32'h0);
        send(11'h3E8);
        wait_y(y, lat, busy_ok);
        check("midrst_cleared_y", 32'(y), 32'h000);
        check("midrst_lat", 32'(lat), 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
